// File: rtl/bist_fail_logger.sv
// BIST fail logger: compares SRAM read data against the engine's expected data
// one cycle after each read, counts mismatches and logs them. Define BIST_FAIL_LOG_EN for the FIFO log.
module bist_fail_logger #(
    parameter int FAIL_DEPTH = 8,
    parameter int CNT_W      = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       addr_in,
    input  logic [3:0]       exp_dat,
    input  logic             w_en_in,
    input  logic             op_done_in,
    input  logic [3:0]       mem_rd_dat,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             done,
    output logic             pass,
    output logic             overflow,
    output logic             fail_valid,
    output logic [7:0]       fail_addr,
    output logic [3:0]       fail_xor,
    input  logic             fail_pop
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nx;
    logic   clr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // clr marks the edge that enters (or re-enters) RUN and wipes the run's results
    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nx = RUN;
                clr      = 1'b1;
            end
            RUN: begin
                if (start)           clr      = 1'b1;
                else if (op_done_in) state_nx = DRAIN;
            end
            DRAIN: state_nx = DONE;
            DONE: if (start) begin
                state_nx = RUN;
                clr      = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One-stage compare pipe: read data arrives the cycle after the read
    logic       capture;
    logic       vld_pipe;
    logic [7:0] pipe_addr;
    logic [3:0] pipe_exp;
    logic       fail_ev;

    assign capture = (state == RUN) && !start && !op_done_in && !w_en_in;

    always_ff @(posedge clk) begin
        if (rst || clr) vld_pipe <= 1'b0;
        else            vld_pipe <= capture;
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            pipe_addr <= addr_in;
            pipe_exp  <= exp_dat;
        end
    end

    assign fail_ev = vld_pipe && !clr && (mem_rd_dat != pipe_exp);

    always_ff @(posedge clk) begin
        if (rst || clr)
            fail_cnt <= '0;
        else if (fail_ev && (fail_cnt != {CNT_W{1'b1}}))
            fail_cnt <= fail_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign done = (state == DONE);
    assign pass = done && (fail_cnt == '0);

`ifdef BIST_FAIL_LOG_EN
    localparam int AW = $clog2(FAIL_DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr;
    logic [11:0]  log_mem [FAIL_DEPTH];
    logic         empty, full, push_ev, pop_ev;
    logic [11:0]  head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ev  = fail_pop && !empty;
    // a pop in the same cycle frees the slot, so a full log still accepts the push
    assign push_ev = fail_ev && (!full || pop_ev);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ev) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop_ev)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ev) log_mem[wr_ptr[AW-1:0]] <= {pipe_addr, pipe_exp ^ mem_rd_dat};
    end

    always_ff @(posedge clk) begin
        if (rst || clr)                  overflow <= 1'b0;
        else if (fail_ev && full && !pop_ev) overflow <= 1'b1;
    end

    assign head       = log_mem[rd_ptr[AW-1:0]];
    assign fail_valid = !empty;
    assign fail_addr  = fail_valid ? head[11:4] : 8'h00;
    assign fail_xor   = fail_valid ? head[3:0]  : 4'h0;
`else
    logic       unused_pop;
    logic [7:0] unused_addr;

    assign unused_pop  = fail_pop;
    assign unused_addr = pipe_addr;
    assign overflow    = 1'b0;
    assign fail_valid  = 1'b0;
    assign fail_addr   = 8'h00;
    assign fail_xor    = 4'h0;
`endif

endmodule

// File: tb/tb_bist_fail_logger.sv
// Scoreboard bench for bist_fail_logger: log entries and run results are queued
// at stimulus time and checked by a monitor when the DUT pops an entry or raises done.
module tb_bist_fail_logger;

`ifdef BIST_FAIL_LOG_EN
    localparam int LOG_EN = 1;
`else
    localparam int LOG_EN = 0;
`endif

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, w_en_in = 1'b1;
    logic       op_done_in = 1'b0, fail_pop = 1'b0;
    logic [7:0] addr_in = 8'h00;
    logic [3:0] exp_dat = 4'h0, mem_rd_dat = 4'h0, pend_act = 4'h0;

    logic [8:0] fail_cnt;
    logic       done, pass, overflow, fail_valid;
    logic [7:0] fail_addr;
    logic [3:0] fail_xor;

    logic [2:0] s_cnt;
    logic       s_done, s_pass, s_ovf;
    logic       sat_unused_fv;
    logic [7:0] sat_unused_addr;
    logic [3:0] sat_unused_xor;

    bist_fail_logger #(.FAIL_DEPTH(8), .CNT_W(9)) u_dut (
        .clk(clk), .rst(rst), .start(start), .addr_in(addr_in), .exp_dat(exp_dat),
        .w_en_in(w_en_in), .op_done_in(op_done_in), .mem_rd_dat(mem_rd_dat),
        .fail_cnt(fail_cnt), .done(done), .pass(pass), .overflow(overflow),
        .fail_valid(fail_valid), .fail_addr(fail_addr), .fail_xor(fail_xor),
        .fail_pop(fail_pop)
    );

    bist_fail_logger #(.FAIL_DEPTH(8), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .start(start), .addr_in(addr_in), .exp_dat(exp_dat),
        .w_en_in(w_en_in), .op_done_in(op_done_in), .mem_rd_dat(mem_rd_dat),
        .fail_cnt(s_cnt), .done(s_done), .pass(s_pass), .overflow(s_ovf),
        .fail_valid(sat_unused_fv), .fail_addr(sat_unused_addr), .fail_xor(sat_unused_xor),
        .fail_pop(fail_pop)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;

    typedef struct { logic [7:0] a; logic [3:0] x; } ent_t;
    typedef struct { int cnt; int scnt; int ps; int ovf; } run_t;
    ent_t log_q[$];
    run_t run_q[$];
    bit   done_seen = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (fail_valid && fail_pop) begin
            if (log_q.size() == 0) chk("log_unexpected_entry", 1, 0);
            else begin
                ent_t e;
                e = log_q.pop_front();
                chk("log_addr", fail_addr, e.a);
                chk("log_xor", fail_xor, e.x);
            end
        end
        if (done && !done_seen) begin
            if (run_q.size() == 0) chk("run_unexpected_done", 1, 0);
            else begin
                run_t r;
                r = run_q.pop_front();
                chk("run_fail_cnt", fail_cnt, r.cnt);
                chk("run_sat_cnt", s_cnt, r.scnt);
                chk("run_pass", pass, r.ps);
                chk("run_sat_pass", s_pass, r.ps);
                chk("run_overflow", overflow, r.ovf);
                chk("run_sat_overflow", s_ovf, r.ovf);
                chk("run_sat_done", s_done, 1);
            end
        end
        done_seen = done;
    end

    // SRAM data for a read shows up one cycle later
    task automatic tick();
        @(posedge clk);
        #1;
        mem_rd_dat = pend_act;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            w_en_in = 1'b1;
            tick();
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [3:0] e, input logic [3:0] act, input bit logged);
        addr_in  = a;
        exp_dat  = e;
        w_en_in  = 1'b0;
        pend_act = act;
        if (logged && LOG_EN != 0) log_q.push_back('{a, e ^ act});
        tick();
        w_en_in = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_run(input int cnt, input int scnt, input int ps, input int ovf);
        run_q.push_back('{cnt, scnt, ps, ovf});
        op_done_in = 1'b1;
        tick();
        op_done_in = 1'b0;
        for (int i = 0; i < 8 && !done; i++) tick();
        chk("done_reached", done, 1);
        tick();
    endtask

    task automatic pop_n(input int n);
        repeat (n) begin
            fail_pop = 1'b1;
            tick();
        end
        fail_pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_fail_valid", fail_valid, 0);
        chk("rst_fail_addr", fail_addr, 0);
        chk("rst_fail_xor", fail_xor, 0);
        rst = 1'b0;
        tick();

        // fault-free sweep of all 256 addresses
        pulse_start();
        for (int i = 0; i < 256; i++) rd(8'(i), 4'(i * 7), 4'(i * 7), 1'b0);
        finish_run(0, 0, 1, 0);
        chk("clean_fail_valid", fail_valid, 0);

        // single fault: 0xF expected, 0xB read -> xor 0x4
        pulse_start();
        rd(8'h3A, 4'hF, 4'hB, 1'b1);
        chk("single_cnt_n1", fail_cnt, 0);
        tick();
        chk("single_cnt_n2", fail_cnt, 1);
        chk("single_valid_n2", fail_valid, LOG_EN);
        chk("single_addr_n2", fail_addr, LOG_EN * 32'h3A);
        chk("single_xor_n2", fail_xor, LOG_EN * 4);
        pop_n(1);
        chk("single_valid_after_pop", fail_valid, 0);
        finish_run(1, 1, 0, 0);

        // ten failures into an 8-deep log: last two dropped
        pulse_start();
        for (int i = 0; i < 10; i++) rd(8'(8'h10 + i), 4'h5, 4'h5 ^ 4'(i + 1), i < 8);
        idle(2);
        chk("ovf_flag_before_done", overflow, LOG_EN);
        finish_run(10, 7, 0, LOG_EN);
        pop_n(8);
        chk("ovf_log_drained", fail_valid, 0);

        // fill the log, then push and pop in the same cycle
        pulse_start();
        for (int i = 0; i < 8; i++) rd(8'(8'h80 + i), 4'hA, 4'hA ^ 4'(i + 1), 1'b1);
        idle(2);
        chk("full_cnt", fail_cnt, 8);
        chk("full_overflow", overflow, 0);
        rd(8'h88, 4'h3, 4'hC, 1'b1);
        fail_pop = 1'b1;
        tick();
        fail_pop = 1'b0;
        chk("pushpop_overflow", overflow, 0);
        chk("pushpop_cnt", fail_cnt, 9);
        chk("sat_cnt_9_fails", s_cnt, 7);
        chk("pushpop_valid", fail_valid, LOG_EN);
        finish_run(9, 7, 0, 0);
        pop_n(8);
        chk("pushpop_log_drained", fail_valid, 0);

        // reset one cycle after a mismatching read
        pulse_start();
        rd(8'h55, 4'h3, 4'h0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_cnt", fail_cnt, 0);
        chk("midrst_valid", fail_valid, 0);
        chk("midrst_done", done, 0);
        rd(8'h56, 4'h3, 4'h0, 1'b0);
        tick();
        chk("idle_ignores_reads", fail_cnt, 0);
        pulse_start();
        rd(8'h57, 4'h9, 4'h9, 1'b0);
        finish_run(0, 0, 1, 0);

        // restart in RUN discards the pending compare
        pulse_start();
        rd(8'h60, 4'h1, 4'h2, 1'b0);
        pulse_start();
        finish_run(0, 0, 1, 0);

        chk("log_q_empty", log_q.size(), 0);
        chk("run_q_empty", run_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bist_fail_logger.md
BIST_FAIL_LOGGER -- requirements
Module: bist_fail_logger

Interface
REQ-001 The block SHALL have parameter FAIL_DEPTH, default 8: failure-log FIFO entries (power of 2, 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 9: failure-counter width in bits.
REQ-003 Port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: single-cycle pulse that arms a new analysis run.
REQ-006 Port addr_in, input, 8: BIST engine address (engine addr_out).
REQ-007 Port exp_dat, input, 4: BIST engine data (engine dat_out); this is the expected value on read cycles.
REQ-008 Port w_en_in, input, 1: engine write enable; 0 means the current cycle is an SRAM read.
REQ-009 Port op_done_in, input, 1: engine op_done.
REQ-010 Port mem_rd_dat, input, 4: SRAM read data, valid exactly 1 cycle after the read cycle.
REQ-011 Port fail_cnt, output, CNT_W: number of mismatching reads in the current run.
REQ-012 Port done, output, 1: the run is complete.
REQ-013 Port pass, output, 1: done and fail_cnt==0.
REQ-014 Port overflow, output, 1: sticky flag; a failure was dropped because the log was full.
REQ-015 Port fail_valid, output, 1: the log head entry is present.
REQ-016 Port fail_addr, output, 8: log head address.
REQ-017 Port fail_xor, output, 4: log head failing-bit mask (expected XOR actual).
REQ-018 Port fail_pop, input, 1: consumer pops the head entry when fail_valid=1.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE to RUN on start; entering RUN SHALL clear fail_cnt, overflow, the log and done in the same edge.
REQ-021 In RUN, every cycle with w_en_in=0 SHALL register {addr_in, exp_dat} into a 1-stage compare pipe with valid set.
REQ-022 On the next cycle the block SHALL compare mem_rd_dat with the registered exp_dat; a mismatch is a failure.
REQ-023 A failure SHALL increment fail_cnt, which saturates at 2^CNT_W-1 with no wrap.
REQ-024 A failure SHALL push {addr, XOR mask} into the log unless it is full; when full the entry is dropped and overflow set to 1.
REQ-025 The failure latency SHALL be: read cycle N, fail_cnt and log updated visibly at cycle N+2.
REQ-026 RUN to DRAIN on the first cycle op_done_in=1; no new reads are captured from that cycle on.
REQ-027 DRAIN SHALL complete any pending compare, then go to DONE after exactly 1 cycle.
REQ-028 In DONE, done=1 and pass=(fail_cnt==0); the log remains readable.
REQ-029 start in DONE SHALL go to RUN (REQ-020 clearing); start in RUN SHALL restart the run and discard any pending compare.
REQ-030 The log SHALL be a first-word-fall-through FIFO: fail_addr and fail_xor show the head whenever fail_valid=1.
REQ-031 fail_pop with an empty log SHALL be ignored.
REQ-032 Simultaneous push and pop SHALL both take effect, including when the log is full (no overflow in that case).
REQ-033 Pointers SHALL wrap modulo FAIL_DEPTH; full/empty SHALL be resolved with an extra pointer bit.
REQ-034 When fail_valid=0, fail_addr and fail_xor SHALL be 0.

Reset
REQ-035 rst SHALL force IDLE, fail_cnt=0, done=0, pass=0, overflow=0, an empty log (fail_valid=0) and the compare pipe valid=0.
REQ-036 rst asserted mid-RUN SHALL abort the run with no partial update on that edge; rst takes priority over start.

Configuration
REQ-037 With macro BIST_FAIL_LOG_EN defined, the FIFO log, overflow, fail_valid/fail_addr/fail_xor and fail_pop behaviour SHALL be implemented as specified.
REQ-038 Without BIST_FAIL_LOG_EN, no FIFO storage SHALL be built; fail_valid, fail_addr, fail_xor and overflow SHALL be tied 0 and fail_pop ignored; fail_cnt, done and pass SHALL be unchanged.

Verification
REQ-039 Fault-free run: start, 256 reads with mem_rd_dat=exp_dat, then op_done_in -> done=1, pass=1, fail_cnt=0, fail_valid=0.
REQ-040 Single fault: read addr 0x3A with exp 0xF and mem 0xB -> at N+2 fail_cnt=1, fail_addr=0x3A, fail_xor=0x4; pop -> fail_valid=0.
REQ-041 Overflow: 10 mismatching reads with FAIL_DEPTH=8 and no pops -> fail_cnt=10, overflow=1, 8 entries logged in order of the first 8 addresses.
REQ-042 Full log with push and pop in the same cycle -> entry count stays 8, overflow stays 0, new entry becomes the tail.
REQ-043 Saturation with CNT_W=3: 9 failures -> fail_cnt=7 with no wrap.
REQ-044 rst asserted 1 cycle after a mismatching read -> fail_cnt=0, fail_valid=0, state IDLE; a subsequent start begins a clean run.
